spi_mem_fsm: RTL and testbench

- Control FSM for the SPI memory slave; sequences the 128x8 synchronous data memory, the address latch, the shift register and the MISO output buffer.
- Receives a command byte from the SPI master: A6..A0 MSB-first, then a R/W bit (1 = read).
- A read then shifts mem[addr] out on MISO. A write captures the next byte into mem[addr].
- Sits between the input conditioners (cs_n, SCLK edge pulses) and the memory/shift-register datapath.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_bit_counter.sv | 39 +++
 rtl/spi_mem_fsm.sv | 134 +++++++++++++
 tb/tb_spi_mem_fsm.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI memory slave controller.
// Pure declarations: no logic and no latency.
package spi_pkg;

   localparam int   WIDTH_DEF      = 8;
   localparam int   ADDR_WIDTH_DEF = 7;
   localparam logic RW_READ        = 1'b1;

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      GET_ADDR   = 4'd1,
      LATCH_ADDR = 4'd2,
      RD_WAIT    = 4'd3,
      RD_LOAD    = 4'd4,
      RD_SHIFT   = 4'd5,
      WR_GET     = 4'd6,
      WR_COMMIT  = 4'd7,
      DONE       = 4'd8
   } state_e;

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating bit counter with clear priority; done_o flags the enable that reaches WIDTH.
// Count is registered (1 cycle); done_o is combinational from en_i and the current count.
module spi_bit_counter #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_i,
   input  logic                 en_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 done_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(WIDTH);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign done_o = en_i && (cnt_q >= (CNT_MAX - 1'b1));

endmodule

// File: rtl/spi_mem_fsm.sv
// SPI memory slave control FSM: command/address capture, 2-cycle read wait, byte shift in/out.
// All strobes registered (1 cycle after the deciding edge); cs_n high aborts to IDLE on the next edge.
// SPI_MEM_FSM_BURST_EN adds addr_inc and streams bytes with auto-increment until cs_n rises.
module spi_mem_fsm
   import spi_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int CNT_WIDTH  = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cs_n,
   input  logic sclk_rise,
   input  logic sclk_fall,
   input  logic rw_bit,
   output logic addr_we,
   output logic dm_we,
   output logic sr_we,
   output logic miso_buff,
   output logic busy
`ifdef SPI_MEM_FSM_BURST_EN
  ,output logic addr_inc
`endif
);

   // The command is ADDR_WIDTH address bits plus the R/W bit, so its last bit has index ADDR_WIDTH.
   localparam logic [CNT_WIDTH-1:0] CMD_LAST     = CNT_WIDTH'(ADDR_WIDTH);
   localparam logic [CNT_WIDTH-1:0] RD_WAIT_LAST = CNT_WIDTH'(1);

   state_e               state_q, state_d;
   logic                 cnt_clr, cnt_en, cnt_done;
   logic [CNT_WIDTH-1:0] cnt;

   logic addr_we_q, addr_we_d;
   logic dm_we_q, dm_we_d;
   logic sr_we_q, sr_we_d;
   logic miso_buff_q, miso_buff_d;
   logic busy_q, busy_d;
   logic addr_inc_q, addr_inc_d;

   spi_bit_counter #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_bit_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .cnt_o  (cnt),
      .done_o (cnt_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_we_q   <= 1'b0;
         dm_we_q     <= 1'b0;
         sr_we_q     <= 1'b0;
         miso_buff_q <= 1'b0;
         busy_q      <= 1'b0;
         addr_inc_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_we_q   <= addr_we_d;
         dm_we_q     <= dm_we_d;
         sr_we_q     <= sr_we_d;
         miso_buff_q <= miso_buff_d;
         busy_q      <= busy_d;
         addr_inc_q  <= addr_inc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (cs_n) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:       state_d = GET_ADDR;
            GET_ADDR:   if (sclk_rise && (cnt == CMD_LAST)) state_d = LATCH_ADDR;
            LATCH_ADDR: state_d = (rw_bit == RW_READ) ? RD_WAIT : WR_GET;
            RD_WAIT:    if (cnt == RD_WAIT_LAST) state_d = RD_LOAD;
            RD_LOAD:    state_d = RD_SHIFT;
`ifdef SPI_MEM_FSM_BURST_EN
            RD_SHIFT:   if (cnt_done) state_d = RD_WAIT;
            WR_GET:     if (cnt_done) state_d = WR_COMMIT;
            WR_COMMIT:  state_d = WR_GET;
`else
            RD_SHIFT:   if (cnt_done) state_d = DONE;
            WR_GET:     if (cnt_done) state_d = WR_COMMIT;
            WR_COMMIT:  state_d = DONE;
`endif
            DONE:       state_d = DONE;
            default:    state_d = IDLE;
         endcase
      end
   end

   // Strobes are decoded from the next state so they line up with the state they belong to.
   always_comb begin
      cnt_en = 1'b0;
      case (state_q)
         GET_ADDR, WR_GET: cnt_en = sclk_rise;
         RD_SHIFT:         cnt_en = sclk_fall;
         RD_WAIT:          cnt_en = 1'b1;
         default:          cnt_en = 1'b0;
      endcase
      cnt_clr = cs_n || cnt_done ||
                (state_q inside {IDLE, LATCH_ADDR, RD_LOAD, WR_COMMIT});

      addr_we_d   = (state_d == LATCH_ADDR);
      dm_we_d     = (state_d == WR_COMMIT);
      sr_we_d     = (state_d == RD_LOAD);
      miso_buff_d = (state_d == RD_SHIFT);
      busy_d      = (state_d != IDLE);
      addr_inc_d  = ((state_q == RD_SHIFT)  && (state_d == RD_WAIT)) ||
                    ((state_q == WR_COMMIT) && (state_d == WR_GET));
   end

   assign addr_we   = addr_we_q;
   assign dm_we     = dm_we_q;
   assign sr_we     = sr_we_q;
   assign miso_buff = miso_buff_q;
   assign busy      = busy_q;

`ifdef SPI_MEM_FSM_BURST_EN
   assign addr_inc = addr_inc_q;
`else
   logic unused_addr_inc;
   assign unused_addr_inc = addr_inc_q;
`endif

endmodule

// File: tb/tb_spi_mem_fsm.sv
// Bench for spi_mem_fsm with a behavioural shift register, address latch and 128x8 memory around it.
// Burst checks are built only when SPI_MEM_FSM_BURST_EN is defined.
module tb_spi_mem_fsm;

   logic clk = 1'b0;
   logic rst_n, cs_n, sclk_rise, sclk_fall, rw_bit;
   logic addr_we, dm_we, sr_we, miso_buff, busy, addr_inc;

   always #5 clk = ~clk;

   spi_mem_fsm dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs_n      (cs_n),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .rw_bit    (rw_bit),
      .addr_we   (addr_we),
      .dm_we     (dm_we),
      .sr_we     (sr_we),
      .miso_buff (miso_buff),
      .busy      (busy)
`ifdef SPI_MEM_FSM_BURST_EN
     ,.addr_inc  (addr_inc)
`endif
   );

`ifndef SPI_MEM_FSM_BURST_EN
   assign addr_inc = 1'b0;
`endif

   logic       mosi, mem_init;
   logic [7:0] sr_q, dout_q;
   logic [7:0] mem [128];
   logic [6:0] alat_q;

   assign rw_bit = sr_q[0];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h96;
      end else if (dm_we) begin
         mem[alat_q] <= sr_q;
      end
      dout_q <= mem[alat_q];
      if (sr_we)                        sr_q <= dout_q;
      else if (sclk_rise && !miso_buff) sr_q <= {sr_q[6:0], mosi};
      else if (sclk_fall && miso_buff)  sr_q <= {sr_q[6:0], 1'b0};
      if (addr_we)       alat_q <= sr_q[7:1];
      else if (addr_inc) alat_q <= alat_q + 7'd1;
   end

   // Event monitor: cumulative counts, sampled just after the falling edge.
   int cyc = 0;
   int n_aw = 0, n_dw = 0, n_sw = 0, n_ai = 0, n_fb = 0, n_blo = 0;
   int aw_cyc = 0, dw_cyc = 0, sw_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      #1;
      if (addr_we)               begin n_aw++; aw_cyc = cyc; end
      if (dm_we)                 begin n_dw++; dw_cyc = cyc; end
      if (sr_we)                 begin n_sw++; sw_cyc = cyc; end
      if (addr_inc)              n_ai++;
      if (miso_buff && sclk_fall) n_fb++;
      if (!busy)                 n_blo++;
   end

   int n_tests = 0, n_fail = 0;
   int rise_cyc = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int outs();
      return int'({addr_inc, busy, miso_buff, sr_we, dm_we, addr_we});
   endfunction

   // One SCLK period (8 clk): MISO sampled at the rise, shift-out at the fall.
   task automatic spi_bit(input logic b, output logic r);
      mosi = b;
      repeat (3) @(negedge clk);
      r = miso_buff ? sr_q[7] : 1'b0;
      sclk_rise = 1'b1;
      rise_cyc  = cyc;
      @(negedge clk);
      sclk_rise = 1'b0;
      repeat (3) @(negedge clk);
      sclk_fall = 1'b1;
      @(negedge clk);
      sclk_fall = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], r);
         rx[i] = r;
      end
   endtask

   initial begin
      logic [7:0] rx, rx1, rx2;
      logic       r;
      int r8, r16, aw0, dw0, sw0, fb0, blo0, ai0;

      rst_n = 1'b0; cs_n = 1'b1; sclk_rise = 1'b0; sclk_fall = 1'b0;
      mosi = 1'b0; mem_init = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outs", outs(), 0);
      rst_n = 1'b1; mem_init = 1'b0;
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      // Asynchronous reset in the middle of the command byte.
      cs_n = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
      chk("get_addr_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_outs", outs(), 0);
      @(negedge clk); cs_n = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);

      // Write 0x5A to 0x12.
      aw0 = n_aw; dw0 = n_dw;
      cs_n = 1'b0; @(negedge clk);
      spi_byte(8'h24, rx); r8 = rise_cyc;
      spi_byte(8'h5A, rx); r16 = rise_cyc;
      cs_n = 1'b1; repeat (2) @(negedge clk);
      chk("wr_aw_count", n_aw - aw0, 1);
      chk("wr_aw_cycle", aw_cyc, r8 + 1);
      chk("wr_dw_count", n_dw - dw0, 1);
      chk("wr_dw_cycle", dw_cyc, r16 + 1);
      chk("wr_mem", int'(mem[7'h12]), 'h5A);

      // Read back 0x12.
      sw0 = n_sw; fb0 = n_fb;
      cs_n = 1'b0; @(negedge clk);
      spi_byte(8'h25, rx);
      spi_byte(8'h00, rx);
      chk("rd_sw_count", n_sw - sw0, 1);
      chk("rd_sw_cycle", sw_cyc, aw_cyc + 3);
      chk("rd_byte", int'(rx), 'h5A);
      chk("rd_buff_falls", n_fb - fb0, 8);
      chk("rd_buff_off", int'(miso_buff), 0);
      chk("rd_busy_end", int'(busy), 1);
      cs_n = 1'b1; repeat (2) @(negedge clk);

      // Abort a write after five data bits.
      dw0 = n_dw;
      cs_n = 1'b0; @(negedge clk);
      spi_byte(8'h24, rx);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
      cs_n = 1'b1;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      repeat (2) @(negedge clk);
      chk("abort_no_dw", n_dw - dw0, 0);
      chk("abort_mem", int'(mem[7'h12]), 'h5A);

      // Two reads separated by a single cs_n-high cycle.
      cs_n = 1'b0; @(negedge clk);
      spi_byte(8'h25, rx);
      spi_byte(8'h00, rx1);
      blo0 = n_blo;
      cs_n = 1'b1; @(negedge clk);
      cs_n = 1'b0; @(negedge clk);
      spi_byte(8'h0B, rx);
      spi_byte(8'h00, rx2);
      chk("b2b_busy_low", n_blo - blo0, 1);
      chk("b2b_first", int'(rx1), 'h5A);
      chk("b2b_second", int'(rx2), 'h93);
      cs_n = 1'b1; repeat (2) @(negedge clk);

      // Top address: write 0xA5 to 0x7F and read it back.
      cs_n = 1'b0; @(negedge clk);
      spi_byte(8'hFE, rx);
      spi_byte(8'hA5, rx);
      cs_n = 1'b1; repeat (2) @(negedge clk);
      chk("wr_top_mem", int'(mem[7'h7F]), 'hA5);
      cs_n = 1'b0; @(negedge clk);
      spi_byte(8'hFF, rx);
      spi_byte(8'h00, rx);
      cs_n = 1'b1; repeat (2) @(negedge clk);
      chk("rd_top_byte", int'(rx), 'hA5);

`ifdef SPI_MEM_FSM_BURST_EN
      // Two-byte read burst from 0x7F wraps to 0x00.
      ai0 = n_ai;
      cs_n = 1'b0; @(negedge clk);
      spi_byte(8'hFF, rx);
      spi_byte(8'h00, rx1);
      spi_byte(8'h00, rx2);
      cs_n = 1'b1; repeat (2) @(negedge clk);
      chk("burst_byte0", int'(rx1), 'hA5);
      chk("burst_byte1", int'(rx2), 'h96);
      chk("burst_inc_count", n_ai - ai0, 2);
      chk("burst_addr_wrap", int'(alat_q), 'h01);
`else
      ai0 = n_ai;
      chk("no_addr_inc", ai0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
